// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake and field bundle for one pipeline stage boundary register.
// master = upstream/downstream environment, slave = the stage register.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 5
);
  // upstream side
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_pc_i;
  logic [31:0]       in_instr_i;
  logic [4:0]        in_a3_i;
  logic              in_we_i;
  logic [EXC_W-1:0]  in_exc_i;
  logic              in_bd_i;
  logic [DATA_W-1:0] in_data_i;
  // downstream side
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_pc_o;
  logic [31:0]       out_instr_o;
  logic [4:0]        out_a3_o;
  logic              out_we_o;
  logic [EXC_W-1:0]  out_exc_o;
  logic              out_bd_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;

  modport master (
    output in_valid_i, in_pc_i, in_instr_i, in_a3_i, in_we_i, in_exc_i,
           in_bd_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_a3_o,
           out_we_o, out_exc_o, out_bd_o, out_data_o, occupancy_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_instr_i, in_a3_i, in_we_i, in_exc_i,
           in_bd_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_a3_o,
           out_we_o, out_exc_o, out_bd_o, out_data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage boundary register (e.g. MEM->WB) with valid/ready handshake,
// synchronous flush and gated register-file write enable.
// Optional feature macro PIPE_SKID_EN: adds a second (skid) entry so that
// in_ready_o is decoded from registered state only. Without it the stage
// holds one entry and in_ready_o passes out_ready_i through combinationally.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  pipe_stage_skid_reg_if.slave bus
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [4:0]        a3;
    logic              we;
    logic [EXC_W-1:0]  exc;
    logic              bd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q;
  entry_t in_ent;
  logic   out_valid;
  logic   in_ready;
  logic   accept;
  logic   pop;
  logic   load_main;

`ifdef PIPE_SKID_EN
  entry_t skid_q;
  logic   load_skid;
  logic   skid_to_main;
`endif

  assign in_ent = '{
    pc:    bus.in_pc_i,
    instr: bus.in_instr_i,
    a3:    bus.in_a3_i,
    we:    bus.in_we_i,
    exc:   bus.in_exc_i,
    bd:    bus.in_bd_i,
    data:  bus.in_data_i
  };

  assign out_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
  // registered ready: no path from out_ready_i
  assign in_ready = (state_q != FULL);
`else
  // single entry: can take a new one if empty or if the held one leaves now
  assign in_ready = ~out_valid | bus.out_ready_i;
`endif

  assign accept = bus.in_valid_i & in_ready;
  assign pop    = out_valid & bus.out_ready_i;

  // next-state and register load decode; flush overrides every transfer
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
`ifdef PIPE_SKID_EN
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
`endif
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
`ifdef PIPE_SKID_EN
            // head still waiting: park the newcomer behind it
            state_d   = FULL;
            load_skid = 1'b1;
`else
            // cannot occur (ready implies pop when occupied); keep it safe
            load_main = 1'b1;
`endif
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        FULL: begin
          if (pop) begin
            state_d      = ONE;
            skid_to_main = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // head entry; flush leaves the fields untouched
  always_ff @(posedge clk) begin
    if (reset)             main_q <= '0;
    else if (load_main)    main_q <= in_ent;
`ifdef PIPE_SKID_EN
    else if (skid_to_main) main_q <= skid_q;
`endif
  end

`ifdef PIPE_SKID_EN
  // second-in-line entry, only written while the head is stalled
  always_ff @(posedge clk) begin
    if (reset)          skid_q <= '0;
    else if (load_skid) skid_q <= in_ent;
  end
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_pc_o    = main_q.pc;
  assign bus.out_instr_o = main_q.instr;
  assign bus.out_a3_o    = main_q.a3;
  assign bus.out_exc_o   = main_q.exc;
  assign bus.out_bd_o    = main_q.bd;
  assign bus.out_data_o  = main_q.data;
  // a faulting instruction must never reach the register file
  assign bus.out_we_o    = main_q.we & out_valid & (main_q.exc == '0);
  assign bus.occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: stimulus pushes expected entries,
// a negedge monitor pops and compares on every downstream transfer.
module tb_pipe_stage_skid_reg;
  localparam int DATA_W = 64;
  localparam int EXC_W  = 5;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] MAX_OCC = 2'd2;
`else
  localparam logic [1:0] MAX_OCC = 2'd1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush_i;

  always #5 clk = ~clk;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus ();

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [4:0]        a3;
    logic              we;
    logic [EXC_W-1:0]  exc;
    logic              bd;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    ent_t e;
    logic we_o;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] a3, input logic we,
                              input logic [EXC_W-1:0] exc, input logic bd);
    ent_t e;
    e.pc    = pc;
    e.instr = {16'h2408, pc[15:0]};
    e.a3    = a3;
    e.we    = we;
    e.exc   = exc;
    e.bd    = bd;
    e.data  = {~pc, pc};
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl);
    bus.in_valid_i  = v;
    bus.in_pc_i     = e.pc;
    bus.in_instr_i  = e.instr;
    bus.in_a3_i     = e.a3;
    bus.in_we_i     = e.we;
    bus.in_exc_i    = e.exc;
    bus.in_bd_i     = e.bd;
    bus.in_data_i   = e.data;
    bus.out_ready_i = ordy;
    flush_i         = fl;
  endtask

  // one cycle, entered and left at posedge+1; acc/ov sampled at the negedge
  task automatic cyc(input logic v, input ent_t e, input logic exp_we, input logic ordy,
                     input logic fl, output logic acc, output logic ov);
    drive(v, e, ordy, fl);
    @(negedge clk);
    acc = v & bus.in_ready_o;
    ov  = bus.out_valid_o;
    if (acc && !fl) q.push_back('{e: e, we_o: exp_we});
    @(posedge clk);
    if (fl) q.delete();
    #1;
  endtask

  // downstream monitor: every transfer must match the scoreboard head
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc %h, expected no entry", bus.out_pc_o);
      end else begin
        mon_x = q.pop_front();
        if (bus.out_pc_o !== mon_x.e.pc || bus.out_instr_o !== mon_x.e.instr ||
            bus.out_a3_o !== mon_x.e.a3 || bus.out_we_o !== mon_x.we_o ||
            bus.out_exc_o !== mon_x.e.exc || bus.out_bd_o !== mon_x.e.bd ||
            bus.out_data_o !== mon_x.e.data) begin
          errors++;
          $display("FAIL pop_data: got pc=%h instr=%h a3=%0d we=%b exc=%0d bd=%b data=%h expected pc=%h instr=%h a3=%0d we=%b exc=%0d bd=%b data=%h",
                   bus.out_pc_o, bus.out_instr_o, bus.out_a3_o, bus.out_we_o, bus.out_exc_o,
                   bus.out_bd_o, bus.out_data_o, mon_x.e.pc, mon_x.e.instr, mon_x.e.a3,
                   mon_x.we_o, mon_x.e.exc, mon_x.e.bd, mon_x.e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, ov;
    ent_t idle;
    idle = '0;

    // reset held two edges with a live offer
    reset = 1'b1;
    drive(1'b1, mk(32'hDEAD_BEEC, 5'd31, 1'b1, 5'd0, 1'b1), 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_out_we",    64'(bus.out_we_o),    64'd0);
    check("rst_occupancy", 64'(bus.occupancy_o), 64'd0);
    check("rst_pc",        64'(bus.out_pc_o),    64'd0);
    check("rst_instr",     64'(bus.out_instr_o), 64'd0);
    check("rst_a3",        64'(bus.out_a3_o),    64'd0);
    check("rst_exc",       64'(bus.out_exc_o),   64'd0);
    check("rst_bd",        64'(bus.out_bd_o),    64'd0);
    check("rst_data",      bus.out_data_o,       64'd0);
    reset = 1'b0;
    drive(1'b0, idle, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

    // streaming, 4 back-to-back entries; third has we=0
    cyc(1'b1, mk(32'h3000, 5'd1, 1'b1, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0, acc, ov);
    check("stream_acc0", 64'(acc), 64'd1);
    check("stream_ov0",  64'(ov),  64'd0);
    cyc(1'b1, mk(32'h3004, 5'd2, 1'b1, 5'd0, 1'b1), 1'b1, 1'b1, 1'b0, acc, ov);
    check("stream_acc1", 64'(acc), 64'd1);
    check("stream_ov1",  64'(ov),  64'd1);
    cyc(1'b1, mk(32'h3008, 5'd3, 1'b0, 5'd0, 1'b0), 1'b0, 1'b1, 1'b0, acc, ov);
    check("stream_acc2", 64'(acc), 64'd1);
    check("stream_ov2",  64'(ov),  64'd1);
    cyc(1'b1, mk(32'h300C, 5'd4, 1'b1, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0, acc, ov);
    check("stream_acc3", 64'(acc), 64'd1);
    check("stream_ov3",  64'(ov),  64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("stream_ov4",  64'(ov),  64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("stream_ov5",  64'(ov),  64'd0);
    check("stream_drained", 64'(q.size()), 64'd0);

`ifdef PIPE_SKID_EN
    // stall: two accepted into main+skid, third refused
    cyc(1'b1, mk(32'h3000, 5'd5, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    check("stall_acc0", 64'(acc), 64'd1);
    cyc(1'b1, mk(32'h3004, 5'd6, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    check("stall_acc1", 64'(acc), 64'd1);
    cyc(1'b1, mk(32'h3008, 5'd7, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    check("stall_acc2", 64'(acc), 64'd0);
    check("stall_occ",      64'(bus.occupancy_o), 64'd2);
    check("stall_in_ready", 64'(bus.in_ready_o),  64'd0);
    check("stall_hold_pc",  64'(bus.out_pc_o),    64'h3000);
    // release: FULL refuses in the pop cycle, then takes the held entry
    cyc(1'b1, mk(32'h3008, 5'd7, 1'b1, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0, acc, ov);
    check("release_acc0", 64'(acc), 64'd0);
    cyc(1'b1, mk(32'h3008, 5'd7, 1'b1, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0, acc, ov);
    check("release_acc1", 64'(acc), 64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("release_ov", 64'(ov), 64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("release_drained", 64'(q.size()), 64'd0);
`else
    // single entry: ready follows out_ready_i combinationally while occupied
    cyc(1'b1, mk(32'h3000, 5'd5, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    check("stall_acc0", 64'(acc), 64'd1);
    drive(1'b1, mk(32'h3004, 5'd6, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0);
    #2;
    check("stall_in_ready", 64'(bus.in_ready_o),  64'd0);
    check("stall_occ",      64'(bus.occupancy_o), 64'd1);
    bus.out_ready_i = 1'b1;
    #1;
    check("pass_in_ready",  64'(bus.in_ready_o),  64'd1);
    @(negedge clk);
    if (bus.in_ready_o === 1'b1) q.push_back('{e: mk(32'h3004, 5'd6, 1'b1, 5'd0, 1'b0), we_o: 1'b1});
    @(posedge clk);
    #1;
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("pass_ov", 64'(ov), 64'd1);
    check("pass_drained", 64'(q.size()), 64'd0);
`endif

    // exception gating: we requested but exc != 0
    cyc(1'b1, mk(32'h3010, 5'd8, 1'b1, 5'd4, 1'b1), 1'b0, 1'b0, 1'b0, acc, ov);
    check("exc_acc",   64'(acc),             64'd1);
    check("exc_valid", 64'(bus.out_valid_o), 64'd1);
    check("exc_we",    64'(bus.out_we_o),    64'd0);
    check("exc_code",  64'(bus.out_exc_o),   64'd4);
    check("exc_a3",    64'(bus.out_a3_o),    64'd8);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("exc_pop_ov", 64'(ov), 64'd1);

    // flush with the stage filled and a new offer in the same cycle
    cyc(1'b1, mk(32'h3020, 5'd9,  1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    cyc(1'b1, mk(32'h3024, 5'd10, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b0, acc, ov);
    check("flush_pre_occ", 64'(bus.occupancy_o), 64'(MAX_OCC));
    cyc(1'b1, mk(32'h3FF0, 5'd11, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 1'b1, acc, ov);
    check("flush_occ",      64'(bus.occupancy_o), 64'd0);
    check("flush_valid",    64'(bus.out_valid_o), 64'd0);
    check("flush_we",       64'(bus.out_we_o),    64'd0);
    check("flush_in_ready", 64'(bus.in_ready_o),  64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("flush_nothing0", 64'(ov), 64'd0);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("flush_nothing1", 64'(ov), 64'd0);
    // stage still works after flush
    cyc(1'b1, mk(32'h3030, 5'd12, 1'b1, 5'd0, 1'b0), 1'b1, 1'b1, 1'b0, acc, ov);
    check("post_flush_acc", 64'(acc), 64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("post_flush_ov", 64'(ov), 64'd1);
    cyc(1'b0, idle, 1'b0, 1'b1, 1'b0, acc, ov);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed stage-boundary registers of the 5-stage MIPS core, e.g. between MEM and WB.
- Carries pc, instr, a3, regwrite, exception code and branch-delay flag, plus a generic payload bus.
- Uses a valid/ready handshake with stall back-pressure, synchronous flush for exceptions or eret, and an optional 2-entry skid buffer.
- With the skid buffer, in_ready_o is fully registered and has no combinational path from out_ready_i.

Parameters:
- DATA_W, 64, width of the generic payload bus (e.g. ao and dm concatenated); range 1..256.
- EXC_W, 5, width of the exception code field; value 0 means "no exception".

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous flush; kills every held entry
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept an entry this cycle
- in_pc_i  in  32  pc of upstream instruction
- in_instr_i  in  32  instruction word
- in_a3_i  in  5  destination register
- in_we_i  in  1  register write enable
- in_exc_i  in  EXC_W  exception code
- in_bd_i  in  1  branch-delay-slot flag
- in_data_i  in  DATA_W  payload
- out_valid_o  out  1  downstream entry valid
- out_ready_i  in  1  downstream accepts
- out_pc_o, out_instr_o  out  32 each  head entry fields
- out_a3_o  out  5  head entry destination
- out_we_o  out  1  gated write enable
- out_exc_o  out  EXC_W  head entry exception code
- out_bd_o  out  1  head entry branch-delay flag
- out_data_o  out  DATA_W  head entry payload
- occupancy_o  out  2  entries held (0..2)

Behaviour:
- Transfers:
  - Accept happens when in_valid_i & in_ready_o at a rising edge.
  - Pop happens when out_valid_o & out_ready_i at a rising edge.
- Reset (sync, highest priority):
  - state = EMPTY; out_valid_o=0, occupancy_o=0, in_ready_o=1 after the reset edge.
  - All field registers cleared to 0 (pc, instr, a3, we, exc, bd, data).
- Flush (second priority, sync):
  - Both entry valids cleared; state = EMPTY.
  - An input offered in the same cycle is dropped.
  - Field registers keep their values; out_we_o reads 0 because valid is 0.
- Skid states and transitions (with PIPE_SKID_EN):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & pop -> ONE (main entry reloaded);
    - accept only -> FULL (new entry goes to the skid register);
    - pop only -> EMPTY.
  - FULL: pop -> ONE (skid entry moves to main); in_ready_o=0, so no accept is possible.
  - in_ready_o = (state != FULL), decoded from the registered state only.
- Ordering: strict FIFO. The head is always the main entry, and out_* are driven from the main register.
- Latency: 1 cycle from accept to out_valid_o when empty; no bubble under continuous flow with out_ready_i=1. Throughput is 1 entry/cycle.
- Output gating:
  - out_we_o = main_we & out_valid_o & (out_exc_o == 0).
  - A faulting instruction never writes the register file.
- Hold: while out_valid_o=1 and out_ready_i=0, all out_* stay stable cycle-to-cycle.
- When out_valid_o=0: the non-we outputs keep their last values and are don't-care downstream; out_we_o=0.
- occupancy_o mirrors the state encoding: EMPTY=0, ONE=1, FULL=2.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined: the 2-entry skid buffer described above; in_ready_o is registered.
- Undefined:
  - Single entry; FULL state absent; occupancy_o never exceeds 1.
  - in_ready_o = ~out_valid_o | out_ready_i (combinational pass-through).
  - Flush and reset rules are unchanged.

Test Plan:
- Reset: hold reset 2 cycles with in_valid_i=1 -> out_valid_o=0, out_we_o=0, all out_* =0, occupancy_o=0; in_ready_o=1 after release.
- Streaming: 4 entries with pc 0x3000, 0x3004, 0x3008, 0x300C and out_ready_i=1 -> each appears 1 cycle after accept, in order, no gaps.
- Stall (skid build): out_ready_i=0 with 3 offers -> 2 accepted, occupancy_o=2, in_ready_o=0, third held upstream. Release -> pc order 0x3000, 0x3004, 0x3008 preserved.
- Exception gating: entry with in_we_i=1, in_a3_i=5'd8, in_exc_i=5'd4 -> out_valid_o=1, out_we_o=0, out_exc_o=4.
- Flush with FULL plus a new offer in the same cycle -> next cycle occupancy_o=0, out_valid_o=0; offered entry never appears.
- Without PIPE_SKID_EN: out_ready_i=0 while an entry is held -> in_ready_o=0. Set out_ready_i=1 -> in_ready_o=1 in the same cycle.
